// File: rtl/systolic_pkg.sv
// Shared types, default sizes and saturation helpers for the systolic matrix-multiply core.
// The saturation helpers are only referenced when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

  localparam int unsigned DefN  = 4;
  localparam int unsigned DefDW = 32;
  localparam int unsigned DefKW = 16;
  localparam int unsigned MaxDW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } state_e;

  typedef logic signed [2*MaxDW-1:0] wide_t;

  function automatic wide_t sat_hi(input int unsigned dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  function automatic logic sat_ovf(input wide_t x, input int unsigned dw);
    return (x > sat_hi(dw)) || (x < (-sat_hi(dw) - wide_t'(1)));
  endfunction

  function automatic wide_t sat_trunc(input wide_t x, input int unsigned dw);
    if (x > sat_hi(dw)) return sat_hi(dw);
    if (x < (-sat_hi(dw) - wide_t'(1))) return -sat_hi(dw) - wide_t'(1);
    return x;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned dw);
    return sat_trunc(a + b, dw);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: accumulates a*b on each advance and forwards a right, b down.
// With SYSTOLIC_SAT_EN the product and sum clamp to the signed DW range and a sticky flag is kept.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DW = DefDW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [DW-1:0] acc
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic          sat
`endif
);

  logic [DW-1:0] r_a, r_b, r_acc, w_acc_nxt;

`ifdef SYSTOLIC_SAT_EN
  logic  r_sat, w_ovf;
  wide_t w_prod, w_prod_sat, w_sum;

  always_comb begin
    w_prod     = wide_t'($signed(a_in)) * wide_t'($signed(b_in));
    w_prod_sat = sat_trunc(w_prod, DW);
    w_sum      = sat_add(wide_t'($signed(r_acc)), w_prod_sat, DW);
    w_ovf      = sat_ovf(w_prod, DW) | sat_ovf(wide_t'($signed(r_acc)) + w_prod_sat, DW);
    w_acc_nxt  = w_sum[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_sat <= 1'b0;
    else if (clr) r_sat <= 1'b0;
    else if (adv) r_sat <= r_sat | w_ovf;
  end

  assign sat = r_sat;
`else
  // Low DW bits of the full signed product, then modulo-2^DW accumulation.
  always_comb begin
    w_acc_nxt = r_acc + DW'((2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in)));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (adv) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= w_acc_nxt;
    end
  end

  assign a_out = r_a;
  assign b_out = r_b;
  assign acc   = r_acc;

endmodule

// File: rtl/systolic_mm_core.sv
// NxN output-stationary systolic core computing C = A*W over a run-time K.
// Optional SYSTOLIC_SAT_EN selects saturating arithmetic and adds the sat_flag output.
module systolic_mm_core
  import systolic_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDW,
  parameter int unsigned KW = DefKW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][DW-1:0]          a_in,
  input  logic [N-1:0][DW-1:0]          w_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0][N-1:0][DW-1:0]   c_out,
  output logic                          busy
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam logic [KW-1:0] DrainLast = KW'(2*N - 2);

  state_e        r_state, w_state_nxt;
  logic [KW-1:0] r_cnt, w_cnt_nxt, r_klen, w_klen_nxt;
  logic          w_adv, w_clr, w_drain;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_klen_nxt  = r_klen;
    w_clr       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_klen_nxt = k_len;
          if (k_len == '0) begin
            w_clr       = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StClear;
          end
        end
      end
      StClear: begin
        w_clr       = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = StFeed;
      end
      StFeed: begin
        if (in_valid) begin
          if (r_cnt == r_klen - KW'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StDrain;
          end else begin
            w_cnt_nxt = r_cnt + KW'(1);
          end
        end
      end
      StDrain: begin
        if (r_cnt == DrainLast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_klen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_klen  <= w_klen_nxt;
    end
  end

  // A stalled FEED cycle freezes every register in the array.
  assign w_adv   = (r_state == StFeed && in_valid) || (r_state == StDrain);
  assign w_drain = (r_state == StDrain);

  assign in_ready  = (r_state == StFeed);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);

  logic [N-1:0][DW-1:0] w_a_edge, w_b_edge;

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] w_a_src, w_b_src;
    assign w_a_src = w_drain ? '0 : a_in[gi];
    assign w_b_src = w_drain ? '0 : w_in[gi];

    if (gi == 0) begin : g_direct
      assign w_a_edge[gi] = w_a_src;
      assign w_b_edge[gi] = w_b_src;
    end else begin : g_chain
      logic [DW-1:0] r_a_sk [gi];
      logic [DW-1:0] r_b_sk [gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sk[s] <= '0;
            r_b_sk[s] <= '0;
          end
        end else if (w_clr) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sk[s] <= '0;
            r_b_sk[s] <= '0;
          end
        end else if (w_adv) begin
          r_a_sk[0] <= w_a_src;
          r_b_sk[0] <= w_b_src;
          for (int s = 1; s < gi; s++) begin
            r_a_sk[s] <= r_a_sk[s-1];
            r_b_sk[s] <= r_b_sk[s-1];
          end
        end
      end

      assign w_a_edge[gi] = r_a_sk[gi-1];
      assign w_b_edge[gi] = r_b_sk[gi-1];
    end
  end

  logic [DW-1:0] w_ah [N][N+1];
  logic [DW-1:0] w_bv [N+1][N];
  logic [N-1:0]  w_unused_a, w_unused_b;
`ifdef SYSTOLIC_SAT_EN
  logic [N*N-1:0] w_sat;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign w_ah[gi][0] = w_a_edge[gi];
    assign w_bv[0][gi] = w_b_edge[gi];
    assign w_unused_a[gi] = ^w_ah[gi][N];
    assign w_unused_b[gi] = ^w_bv[N][gi];

    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DW(DW)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .adv  (w_adv),
        .clr  (w_clr),
        .a_in (w_ah[gi][gj]),
        .b_in (w_bv[gi][gj]),
        .a_out(w_ah[gi][gj+1]),
        .b_out(w_bv[gi+1][gj]),
        .acc  (c_out[gi][gj])
`ifdef SYSTOLIC_SAT_EN
        ,
        .sat  (w_sat[gi*N+gj])
`endif
      );
    end
  end

`ifdef SYSTOLIC_SAT_EN
  assign sat_flag = (r_state == StDone) && (|w_sat);
`endif

endmodule

// File: tb/tb_systolic_mm_core.sv
// Scoreboard bench for systolic_mm_core (N=4, DW=32): directed jobs push expected results,
// a negedge monitor pops and checks them at each result handshake.
module tb_systolic_mm_core;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 16;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
  typedef struct {
    mat_t c;
    int   lat;
    int   t0;
    int   id;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic [KW-1:0]               k_len = '0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [N-1:0][DW-1:0]        a_in = '0;
  logic [N-1:0][DW-1:0]        w_in = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  mat_t                        c_out;
  logic                        busy;
`ifdef SYSTOLIC_SAT_EN
  logic                        sat_flag;
`endif

  systolic_mm_core #(
    .N (N),
    .DW(DW),
    .KW(KW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_out    (c_out),
    .busy     (busy)
`ifdef SYSTOLIC_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];

  logic [DW-1:0] a_m [N][16];
  logic [DW-1:0] w_m [16][N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mac(input logic [DW-1:0] acc, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
`ifdef SYSTOLIC_SAT_EN
    begin
      logic signed [2*DW-1:0] hi, lo, s;
      hi = (2*DW)'(64'sh7fff_ffff);
      lo = -hi - (2*DW)'(1);
      if (p > hi) p = hi;
      if (p < lo) p = lo;
      s = (2*DW)'($signed(acc)) + p;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return DW'(s);
    end
`else
    return acc + DW'(p);
`endif
  endfunction

  function automatic mat_t model(input int k);
    mat_t c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int kk = 0; kk < k; kk++) c[i][j] = mac(c[i][j], a_m[i][kk], w_m[kk][j]);
    return c;
  endfunction

  // Monitor: scoreboard pop on each accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) rise_cyc = cyc;
    prev_v = out_valid;
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got out_valid=1, expected no pending job");
      end else begin
        e = sb.pop_front();
        if (c_out !== e.c) begin
          n_fail++;
          for (int i = N - 1; i >= 0; i--)
            for (int j = N - 1; j >= 0; j--)
              if (c_out[i][j] !== e.c[i][j])
                $display("FAIL job%0d_c[%0d][%0d]: got %0h, expected %0h",
                         e.id, i, j, c_out[i][j], e.c[i][j]);
        end
        if (e.lat >= 0) check($sformatf("job%0d_latency", e.id), 64'(rise_cyc - e.t0),
                              64'(e.lat));
      end
    end
  end

  task automatic garbage();
    for (int i = 0; i < N; i++) begin
      a_in[i] = $urandom();
      w_in[i] = $urandom();
    end
  endtask

  task automatic wait_idle(input int id);
    int guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (busy) begin
      check($sformatf("job%0d_timeout", id), 64'(busy), 64'(0));
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      sb.delete();
    end
  endtask

  // Runs one job starting in the current (idle) cycle. stall: valid pattern 1,0,0 repeating.
  task automatic run_job(input int k, input bit stall, input bit hold, input bit abort,
                         input bit poke, input bit use_model, input mat_t c_fixed, input int id);
    exp_t e;
    int   b = 0;
    int   p = 0;
    int   guard = 0;
    bit   ready_ok = 1'b1;
    bit   acc_beat;
    mat_t snap;
    out_ready = hold ? 1'b0 : 1'b1;
    start = 1'b1;
    k_len = KW'(k);
    e.c   = use_model ? model(k) : c_fixed;
    e.lat = stall ? -1 : ((k == 0) ? 1 : k + 2 * N + 1);
    e.t0  = cyc;
    e.id  = id;
    if (!abort) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    k_len = KW'($urandom_range(1, 9));
    while (b < k && guard < 400) begin
      if (guard > 0 && !in_ready) ready_ok = 1'b0;
      if (in_ready) begin
        in_valid = stall ? (p % 3 == 0) : 1'b1;
        p++;
        if (in_valid) begin
          for (int i = 0; i < N; i++) begin
            a_in[i] = a_m[i][b];
            w_in[i] = w_m[b][i];
          end
        end else garbage();
        if (poke && b == 2) start = 1'b1;
      end else begin
        in_valid = 1'b1;
        garbage();
      end
      acc_beat = in_ready && in_valid;
      @(posedge clk);
      if (acc_beat) b++;
      #1;
      start = 1'b0;
      guard++;
    end
    if (stall) check($sformatf("job%0d_in_ready_held", id), 64'(ready_ok), 64'(1));
    in_valid = 1'b1;
    garbage();
    if (abort) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_out_valid", 64'(out_valid), 64'(0));
      check("abort_in_ready", 64'(in_ready), 64'(0));
      check("abort_c_out", 64'(|c_out), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      return;
    end
    if (hold) begin
      guard = 0;
      while (!out_valid && guard < 400) begin
        @(posedge clk);
        #1;
        guard++;
      end
      snap = c_out;
      repeat (5) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("job%0d_hold_valid", id), 64'(out_valid), 64'(1));
      check($sformatf("job%0d_hold_stable", id), 64'(c_out == snap), 64'(1));
      out_ready = 1'b1;
    end
    wait_idle(id);
    in_valid = 1'b0;
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 16; kk++) begin
        a_m[i][kk] = '0;
        w_m[kk][i] = '0;
      end
  endtask

  initial begin
    mat_t cf;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_c_out", 64'(|c_out), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Job 1: 2x2 example embedded in the 4x4 array.
    clear_ops();
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    w_m[0][0] = 5; w_m[0][1] = 6; w_m[1][0] = 7; w_m[1][1] = 8;
    cf = '0;
    cf[0][0] = 19; cf[0][1] = 22; cf[1][0] = 43; cf[1][1] = 50;
    run_job(2, 0, 0, 0, 0, 0, cf, 1);

    // Job 2: identity A, C must equal W; result held by out_ready low.
    clear_ops();
    for (int i = 0; i < N; i++) a_m[i][i] = 1;
    for (int kk = 0; kk < N; kk++)
      for (int j = 0; j < N; j++) begin
        w_m[kk][j] = $urandom();
        cf[kk][j]  = w_m[kk][j];
      end
    run_job(4, 0, 1, 0, 0, 0, cf, 2);

    // Job 3: K=8 with stalls, signed operands, start poked mid-feed.
    for (int kk = 0; kk < 8; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = DW'($urandom_range(0, 200)) - DW'(100);
        w_m[kk][i] = (kk % 2 == 0) ? $urandom() : DW'($urandom_range(0, 50)) - DW'(25);
      end
    run_job(8, 1, 0, 0, 1, 1, '0, 3);

    // Job 4: k_len = 0 gives an all-zero result one cycle after start.
    run_job(0, 0, 0, 0, 0, 0, '0, 4);

    // Job 5: products that overflow DW.
    for (int kk = 0; kk < 2; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = 32'h0001_0000;
        w_m[kk][i] = 32'h0001_0001;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
`ifdef SYSTOLIC_SAT_EN
        cf[i][j] = 32'h7fff_ffff;
`else
        cf[i][j] = 32'h0002_0000;
`endif
    run_job(2, 0, 0, 0, 0, 0, cf, 5);

    // Abort in DRAIN cycle 2, then a fresh K=3 job.
    for (int kk = 0; kk < 4; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = $urandom();
        w_m[kk][i] = $urandom();
      end
    run_job(4, 0, 0, 1, 0, 1, '0, 6);
    @(posedge clk);
    #1;
    for (int kk = 0; kk < 3; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = DW'(kk * 10 + i + 1);
        w_m[kk][i] = DW'(i) - DW'(kk * 3);
      end
    run_job(3, 0, 0, 0, 0, 1, '0, 7);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
